// File: rtl/fetch_decode_alu_if.sv
// Sequencer-facing bus for fetch_decode_alu: fetch, program load, decode and ALU.
// Flag outputs exist only when ALU_FLAGS_EN is defined.
interface fetch_decode_alu_if;
  logic [6:0]  pc;
  logic        if_en;
  logic        ld_we;
  logic [6:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] ir;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [1:0]  alusc;
  logic [1:0]  wrreg;
  logic        sigwr;
  logic        sigon;
  logic [1:0]  res;
  logic [2:0]  br;
  logic [2:0]  st;
  logic [31:0] alu_out;
`ifdef ALU_FLAGS_EN
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;
`endif

  modport master (
    output pc, if_en, ld_we, ld_addr, ld_data, alu_a, alu_b,
    input  ir, alu_op, alusc, wrreg, sigwr, sigon, res, br, st,
`ifdef ALU_FLAGS_EN
    input  flag_z, flag_n, flag_v,
`endif
    input  alu_out
  );

  modport slave (
    input  pc, if_en, ld_we, ld_addr, ld_data, alu_a, alu_b,
    output ir, alu_op, alusc, wrreg, sigwr, sigon, res, br, st,
`ifdef ALU_FLAGS_EN
    output flag_z, flag_n, flag_v,
`endif
    output alu_out
  );
endinterface

// File: rtl/fetch_decode_alu.sv
// Instruction memory, IR, combinational decoder and 32-bit ALU.
// Optional ALU flags (flag_z/flag_n/flag_v) are built when ALU_FLAGS_EN is defined.
module fetch_decode_alu #(
  parameter int IMEM_DEPTH = 128,
  parameter int XLEN       = 32
) (
  input logic             clk,
  input logic             rst_n,
  fetch_decode_alu_if.slave bus
);
  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] ir_q;
  logic [5:0]      op;
  logic [3:0]      alu_op;
  logic [1:0]      alusc;
  logic [1:0]      wrreg;
  logic            sigwr;
  logic            sigon;
  logic [1:0]      res;
  logic [2:0]      br;
  logic [2:0]      st;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] y;
  logic [4:0]      sh;

  // Nonblocking update gives read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (bus.ld_we) imem[bus.ld_addr] <= bus.ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ir_q <= '0;
    else if (bus.if_en) ir_q <= imem[bus.pc];
  end

  assign op = ir_q[31:26];

  always_comb begin
    alu_op = '0;
    alusc  = '0;
    wrreg  = '0;
    sigwr  = 1'b0;
    sigon  = 1'b0;
    res    = '0;
    br     = '0;
    st     = '0;
    unique case (1'b1)
      op == 6'h01: begin
        alu_op = ir_q[3:0];
        wrreg  = 2'd1;
        res    = 2'd2;
      end
      op >= 6'h02 && op <= 6'h0A: begin
        alu_op = 4'(op - 6'h02);
        alusc  = 2'd1;
        wrreg  = 2'd2;
        res    = 2'd2;
      end
      op == 6'h10: begin
        alusc = 2'd1;
        sigon = 1'b1;
        wrreg = 2'd2;
        res   = 2'd3;
      end
      op == 6'h11: begin
        alusc = 2'd1;
        sigon = 1'b1;
        sigwr = 1'b1;
      end
      op == 6'h12: begin
        wrreg = 2'd2;
        res   = 2'd1;
      end
      op == 6'h20: begin
        br    = 3'd1;
        alusc = 2'd3;
      end
      op >= 6'h21 && op <= 6'h23: begin
        br    = 3'(op - 6'h1F);
        alusc = 2'd2;
      end
      op >= 6'h30 && op <= 6'h33: st = 3'(op - 6'h2F);
      default: ;
    endcase
  end

  assign a  = bus.alu_a;
  assign b  = bus.alu_b;
  assign sh = b[4:0];

  always_comb begin
    y = '0;
    unique case (alu_op)
      4'd0: y = a + b;
      4'd1: y = a - b;
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = ~a;
      4'd6: y = a << sh;
      4'd7: y = a >> sh;
      4'd8: y = $signed(a) >>> sh;
      default: y = '0;
    endcase
  end

  assign bus.ir      = ir_q;
  assign bus.alu_op  = alu_op;
  assign bus.alusc   = alusc;
  assign bus.wrreg   = wrreg;
  assign bus.sigwr   = sigwr;
  assign bus.sigon   = sigon;
  assign bus.res     = res;
  assign bus.br      = br;
  assign bus.st      = st;
  assign bus.alu_out = y;

`ifdef ALU_FLAGS_EN
  logic v;
  always_comb begin
    v = 1'b0;
    if (alu_op == 4'd0)
      v = (a[31] == b[31]) && (y[31] != a[31]);
    else if (alu_op == 4'd1)
      v = (a[31] != b[31]) && (y[31] != a[31]);
  end
  assign bus.flag_z = (y == '0);
  assign bus.flag_n = y[31];
  assign bus.flag_v = v;
`endif
endmodule

// File: tb/tb_fetch_decode_alu.sv
// Directed bench for fetch_decode_alu with an IR scoreboard.
module tb_fetch_decode_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] mem [128];
  logic [31:0] sb [$];
  logic [31:0] last_ir = '0;

  fetch_decode_alu_if bus ();

  fetch_decode_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {alu_op, alusc, wrreg, sigwr, sigon, res, br, st}
  task automatic chk_dec(input string tag, input logic [3:0] o,
                         input logic [1:0] sc, input logic [1:0] wr,
                         input logic sw, input logic so,
                         input logic [1:0] rs, input logic [2:0] b,
                         input logic [2:0] s);
    chk(tag,
        32'({bus.alu_op, bus.alusc, bus.wrreg, bus.sigwr, bus.sigon,
             bus.res, bus.br, bus.st}),
        32'({o, sc, wr, sw, so, rs, b, s}));
  endtask

  task automatic step(input logic [6:0] fa, input logic fe,
                      input logic lw, input logic [6:0] la,
                      input logic [31:0] ld);
    @(negedge clk);
    bus.pc = fa;
    bus.if_en = fe;
    bus.ld_we = lw;
    bus.ld_addr = la;
    bus.ld_data = ld;
    if (fe) sb.push_back(mem[fa]);
    if (lw) mem[la] = ld;
    @(posedge clk);
    #1;
    bus.if_en = 1'b0;
    bus.ld_we = 1'b0;
    if (fe) last_ir = sb.pop_front();
    chk(fe ? "ir_fetch" : "ir_hold", bus.ir, last_ir);
  endtask

  task automatic put_ir(input logic [31:0] w);
    step(7'd0, 1'b0, 1'b1, 7'd100, w);
    step(7'd100, 1'b1, 1'b0, 7'd0, 32'd0);
  endtask

  task automatic alu_t(input string tag, input logic [3:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    put_ir(32'h0400_0000 | 32'(fn));
    bus.alu_a = a;
    bus.alu_b = b;
    #1;
    chk(tag, bus.alu_out, exp);
  endtask

  initial begin
    bus.pc = '0;
    bus.if_en = 1'b0;
    bus.ld_we = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    bus.alu_a = '0;
    bus.alu_b = '0;
    #2;
    chk("rst_ir", bus.ir, 32'd0);
    chk_dec("rst_dec", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    step(7'd0, 1'b0, 1'b1, 7'd5, 32'h0422_0800);
    step(7'd5, 1'b1, 1'b0, 7'd0, 32'd0);
    chk("ld_fetch", bus.ir, 32'h0422_0800);
    chk_dec("rtype", 0, 0, 1, 0, 0, 2, 0, 0);
    step(7'd3, 1'b0, 1'b0, 7'd0, 32'd0);

    // Async reset mid-cycle
    step(7'd0, 1'b0, 1'b1, 7'd6, 32'h0400_0000);
    step(7'd6, 1'b1, 1'b0, 7'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", bus.ir, 32'd0);
    chk_dec("async_dec", 0, 0, 0, 0, 0, 0, 0, 0);
    last_ir = '0;
    @(negedge clk);
    rst_n = 1'b1;

    alu_t("add", 4'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFC);
    alu_t("sub", 4'd1, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFF6);
    alu_t("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    alu_t("or", 4'd3, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
    alu_t("xor", 4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    alu_t("not", 4'd5, 32'h1234_5678, 32'd0, 32'hEDCB_A987);
    alu_t("sra", 4'd8, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_t("srl", 4'd7, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_t("sll_a", 4'd6, 32'h8000_0000, 32'h24, 32'h0000_0000);
    alu_t("sll_b", 4'd6, 32'h0000_0011, 32'h24, 32'h0000_0110);
    alu_t("op12", 4'd12, 32'h1234_5678, 32'h1, 32'h0);

    // I-type SUB (opcode 0x03)
    put_ir(32'h0C00_0005);
    chk_dec("itype", 1, 1, 2, 0, 0, 2, 0, 0);
    bus.alu_a = 32'd10;
    bus.alu_b = 32'd3;
    #1;
    chk("itype_alu", bus.alu_out, 32'd7);

    put_ir(32'h4000_FFFC);
    chk_dec("ld", 0, 1, 2, 0, 1, 3, 0, 0);
    put_ir(32'h4400_0004);
    chk_dec("st", 0, 1, 0, 1, 1, 0, 0, 0);
    put_ir(32'h4800_0000);
    chk_dec("move", 0, 0, 2, 0, 0, 1, 0, 0);
    put_ir(32'h8000_0000);
    chk_dec("br", 0, 3, 0, 0, 0, 0, 1, 0);
    put_ir(32'h8400_0000);
    chk_dec("bltz", 0, 2, 0, 0, 0, 0, 2, 0);
    put_ir(32'h8800_0000);
    chk_dec("bgtz", 0, 2, 0, 0, 0, 0, 3, 0);
    put_ir(32'h8C00_0000);
    chk_dec("bz", 0, 2, 0, 0, 0, 0, 4, 0);
    put_ir(32'hC000_0000);
    chk_dec("push", 0, 0, 0, 0, 0, 0, 0, 1);
    put_ir(32'hCC00_0000);
    chk_dec("ret", 0, 0, 0, 0, 0, 0, 0, 4);
    put_ir(32'hFC00_FFFF);
    chk_dec("unk3f", 0, 0, 0, 0, 0, 0, 0, 0);

    // Same-address fetch and load
    step(7'd0, 1'b0, 1'b1, 7'd9, 32'hAAAA_0001);
    step(7'd9, 1'b1, 1'b1, 7'd9, 32'hBBBB_0002);
    chk("coll_old", bus.ir, 32'hAAAA_0001);
    step(7'd9, 1'b1, 1'b0, 7'd0, 32'd0);
    chk("coll_new", bus.ir, 32'hBBBB_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_decode_alu.md
Name: fetch_decode_alu

Overview:
- Front half of the multi-cycle processor datapath: 128x32 instruction memory, combinational instruction decoder, and 32-bit ALU.
- The sequencer supplies `pc`, the fetch strobe and the ALU operands.
- The block returns the latched instruction register, all decoded control fields, and the ALU result.
- Register bank, data memory and the state sequencer sit outside the block.

Parameters:
- IMEM_DEPTH, 128: instruction words; address width is 7 bits.
- XLEN, 32: instruction and data width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  7  fetch address (word index).
- if_en  in  1  fetch strobe; `ir` loads `imem[pc]` on the rising edge when high.
- ld_we  in  1  program-load write enable.
- ld_addr  in  7  program-load address.
- ld_data  in  32  program-load word.
- ir  out  32  instruction register.
- alu_a  in  32  ALU operand A (signed).
- alu_b  in  32  ALU operand B (signed).
- alu_op  out  4  decoded ALU operation.
- alusc  out  2  B source: 0 = rt register, 1 = sext imm16, 2 = sext imm21, 3 = sext imm26.
- wrreg  out  2  writeback destination: 0 = none, 1 = rd `ir[15:11]`, 2 = rt `ir[20:16]`, 3 = rs `ir[25:21]`.
- sigwr  out  1  data memory write.
- sigon  out  1  data memory enable.
- res  out  2  writeback source: 0 = none, 1 = rs value, 2 = ALU, 3 = memory.
- br  out  3  branch type: 0 = none, 1 = always, 2 = rs<0, 3 = rs>0, 4 = rs==0.
- st  out  3  stack operation: 0 = none, 1 = push, 2 = pop, 3 = call, 4 = ret.
- alu_out  out  32  ALU result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - `ir` = 0, so all decode outputs are 0 (NOP).
  - Instruction memory contents are not cleared.
- Fetch:
  - At posedge with `if_en` = 1, `ir` <= `imem[pc]`. Otherwise `ir` holds.
  - Latency: one clock from strobe to new `ir`.
- Program load:
  - At posedge with `ld_we` = 1, `imem[ld_addr]` <= `ld_data`.
  - Fetch and load to the same address in the same cycle: `ir` receives the old word (read-before-write).
  - Memory contents after power-up are undefined until loaded.
- Decode: purely combinational from `ir`. Opcode is `ir[31:26]`. Any field not listed below is 0.
  - 0x00 NOP: all fields 0.
  - 0x01 R-type: `alu_op` = `ir[3:0]`, `alusc` = 0, `wrreg` = 1, `res` = 2.
  - 0x02..0x0A I-type ALU: `alu_op` = opcode-2, `alusc` = 1, `wrreg` = 2, `res` = 2.
  - 0x10 LD: `alu_op` = ADD, `alusc` = 1, `sigon` = 1, `wrreg` = 2, `res` = 3.
  - 0x11 ST: `alu_op` = ADD, `alusc` = 1, `sigon` = 1, `sigwr` = 1.
  - 0x12 MOVE (rt <= rs): `wrreg` = 2, `res` = 1.
  - 0x20 BR: `br` = 1, `alusc` = 3, `alu_op` = ADD.
  - 0x21 BLTZ: `br` = 2, `alusc` = 2, `alu_op` = ADD.
  - 0x22 BGTZ: `br` = 3, `alusc` = 2, `alu_op` = ADD.
  - 0x23 BZ: `br` = 4, `alusc` = 2, `alu_op` = ADD.
  - 0x30..0x33 PUSH/POP/CALL/RET: `st` = 1..4 respectively.
  - All other opcodes: NOP.
- ALU: combinational from `alu_a`, `alu_b` and the decoded `alu_op`. 32-bit two's complement, wrap on overflow, no exceptions.
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT: ~A.
  - 6 SLL: A<<B[4:0].
  - 7 SRL: logical shift right by B[4:0].
  - 8 SRA: arithmetic shift right by B[4:0].
  - 9..15: result 0.
- Shift amounts use only `B[4:0]`; upper bits of B are ignored.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined: extra outputs `flag_z`, `flag_n`, `flag_v` (all combinational).
  - `flag_z`: `alu_out` == 0.
  - `flag_n`: `alu_out[31]`.
  - `flag_v`: signed overflow for ADD/SUB; 0 for all other ops.
- When undefined: the ports do not exist and no flag logic is built.

Test Plan:
- Reset: pulse rst_n low mid-cycle after `ir` = 0x04000000 -> `ir` = 0 immediately; all control fields 0.
- Load and fetch:
  - Load addr 5 = 0x0422_0800, then pc = 5 with `if_en` -> next cycle `ir` = 0x04220800.
  - Decodes R-type: `wrreg` = 1, `res` = 2, `alusc` = 0.
  - Without `if_en`, `ir` holds.
- ALU sweep:
  - A = -7, B = 3: ADD -> -4; SUB -> -10.
  - A = 0x80000000, B = 4: SRA -> 0xF8000000; SRL -> 0x08000000.
  - A = 0x80000000, B = 0x24: SLL shifts by 4.
  - `alu_op` = 12 -> 0.
- LD/ST decode:
  - `ir` = 0x4000_FFFC (LD) -> `sigon` = 1, `sigwr` = 0, `alusc` = 1, `res` = 3, `wrreg` = 2.
  - `ir` = 0x4400_0004 (ST) -> `sigon` = 1, `sigwr` = 1, `wrreg` = 0.
- Branch decode:
  - Opcodes 0x20..0x23 -> `br` = 1..4, `alusc` = 3 (BR) or 2 (others), `alu_op` = 0.
  - Unknown opcode 0x3F -> all fields 0.
- Same-address collision: fetch and load at addr 9 in the same cycle -> `ir` = old word; the next fetch returns the new word.
